// File: rtl/axi_wr_native_bridge_if.sv
// Signal bundle between an AXI4 write master, the write bridge and a LiteDRAM-style native port.
// The "slave" modport is the bridge's view; "master" is the surrounding environment.
interface axi_wr_native_bridge_if #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int NADDR_W = 32,
  parameter int ID_W    = 1
);
  localparam int BYTES = DATA_W / 8;

  logic               axi_aw_valid;
  logic               axi_aw_ready;
  logic [ADDR_W-1:0]  axi_aw_payload_addr;
  logic [1:0]         axi_aw_payload_burst;
  logic [7:0]         axi_aw_payload_len;
  logic [3:0]         axi_aw_payload_size;
  logic [ID_W-1:0]    axi_aw_payload_id;
  logic               axi_w_valid;
  logic               axi_w_ready;
  logic               axi_w_last;
  logic [DATA_W-1:0]  axi_w_payload_data;
  logic [BYTES-1:0]   axi_w_payload_strb;
  logic               axi_b_valid;
  logic               axi_b_ready;
  logic [1:0]         axi_b_payload_resp;
  logic [ID_W-1:0]    axi_b_payload_id;
  logic               native_cmd_valid;
  logic               native_cmd_ready;
  logic               native_cmd_payload_we;
  logic [NADDR_W-1:0] native_cmd_payload_addr;
  logic               wdata_valid;
  logic               wdata_ready;
  logic [DATA_W-1:0]  wdata_payload_data;
  logic [BYTES-1:0]   wdata_payload_we;

  modport slave (
    input  axi_aw_valid, axi_aw_payload_addr, axi_aw_payload_burst, axi_aw_payload_len,
           axi_aw_payload_size, axi_aw_payload_id, axi_w_valid, axi_w_last,
           axi_w_payload_data, axi_w_payload_strb, axi_b_ready, native_cmd_ready, wdata_ready,
    output axi_aw_ready, axi_w_ready, axi_b_valid, axi_b_payload_resp, axi_b_payload_id,
           native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
           wdata_valid, wdata_payload_data, wdata_payload_we
  );

  modport master (
    output axi_aw_valid, axi_aw_payload_addr, axi_aw_payload_burst, axi_aw_payload_len,
           axi_aw_payload_size, axi_aw_payload_id, axi_w_valid, axi_w_last,
           axi_w_payload_data, axi_w_payload_strb, axi_b_ready, native_cmd_ready, wdata_ready,
    input  axi_aw_ready, axi_w_ready, axi_b_valid, axi_b_payload_resp, axi_b_payload_id,
           native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
           wdata_valid, wdata_payload_data, wdata_payload_we
  );
endinterface

// File: rtl/axi_wr_native_bridge.sv
// AXI4 write burst -> per-beat native commands plus pass-through write data, then one B response.
// Command and data streams advance independently; an errored burst drains W without native traffic.
module axi_wr_native_bridge #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int NADDR_W = 32,
  parameter int ID_W    = 1
) (
  input logic                  clk,
  input logic                  rst,
  axi_wr_native_bridge_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_WRAP  = 2'd2;
  localparam logic [1:0] B_RSVD  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_burst;
  logic [7:0]        r_len;
  logic [ID_W-1:0]   r_id;
  logic [8:0]        r_cmd_cnt;
  logic [8:0]        r_data_cnt;
  logic              r_err;
  logic              r_lastmis;

  logic              w_aw_ready;
  logic              w_aw_hs;
  logic              w_wrap_len_ok;
  logic              w_aw_err;
  logic [8:0]        w_len9;
  logic              w_cmd_act;
  logic              w_data_act;
  logic              w_cmd_hs;
  logic              w_w_ready;
  logic              w_w_hs;
  logic [8:0]        w_cmd_cnt_nxt;
  logic [8:0]        w_data_cnt_nxt;
  logic              w_done;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_wrap_mask;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_aw_ready = (r_state == S_IDLE) & ~rst;
  assign w_aw_hs    = bus.axi_aw_valid & w_aw_ready;

  assign w_wrap_len_ok = (bus.axi_aw_payload_len == 8'd1) | (bus.axi_aw_payload_len == 8'd3) |
                         (bus.axi_aw_payload_len == 8'd7) | (bus.axi_aw_payload_len == 8'd15);
  assign w_aw_err = (bus.axi_aw_payload_size != 4'(SHIFT)) | (bus.axi_aw_payload_burst == B_RSVD) |
                    ((bus.axi_aw_payload_burst == B_WRAP) & ~w_wrap_len_ok);

  assign w_len9     = {1'b0, r_len};
  assign w_cmd_act  = (r_state == S_BURST) & (r_cmd_cnt <= w_len9) & ~r_err;
  assign w_data_act = (r_state == S_BURST) & (r_data_cnt <= w_len9);
  assign w_cmd_hs   = w_cmd_act & bus.native_cmd_ready;
  // Errored bursts sink W beats unconditionally so the master is never stalled.
  assign w_w_ready  = r_err ? w_data_act : (bus.wdata_ready & w_data_act);
  assign w_w_hs     = bus.axi_w_valid & w_w_ready;

  assign w_cmd_cnt_nxt  = r_cmd_cnt + 9'(w_cmd_hs);
  assign w_data_cnt_nxt = r_data_cnt + 9'(w_w_hs);
  // Look at post-handshake counts so B follows the final handshake by one cycle.
  assign w_done = (r_err | (w_cmd_cnt_nxt > w_len9)) & (w_data_cnt_nxt > w_len9);

  // WRAP window is (len+1)*BYTES; len+1 is a power of two, so the mask is len:ones.
  assign w_addr_inc  = r_addr + ADDR_W'(BYTES);
  assign w_wrap_mask = (ADDR_W'(r_len) << SHIFT) | ADDR_W'(BYTES - 1);

  always_comb begin
    w_addr_nxt = w_addr_inc;
    case (r_burst)
      B_FIXED: w_addr_nxt = r_addr;
      B_WRAP:  w_addr_nxt = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default: w_addr_nxt = w_addr_inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_burst    <= '0;
      r_len      <= '0;
      r_id       <= '0;
      r_cmd_cnt  <= '0;
      r_data_cnt <= '0;
      r_err      <= 1'b0;
      r_lastmis  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_aw_hs) begin
          r_addr     <= bus.axi_aw_payload_addr;
          r_burst    <= bus.axi_aw_payload_burst;
          r_len      <= bus.axi_aw_payload_len;
          r_id       <= bus.axi_aw_payload_id;
          r_cmd_cnt  <= '0;
          r_data_cnt <= '0;
          r_err      <= w_aw_err;
          r_lastmis  <= 1'b0;
          r_state    <= S_BURST;
        end
        S_BURST: begin
          if (w_cmd_hs) begin
            r_cmd_cnt <= w_cmd_cnt_nxt;
            r_addr    <= w_addr_nxt;
          end
          if (w_w_hs) begin
            r_data_cnt <= w_data_cnt_nxt;
            if (bus.axi_w_last != (r_data_cnt == w_len9)) r_lastmis <= 1'b1;
          end
          if (w_done) r_state <= S_RESP;
        end
        S_RESP: if (bus.axi_b_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.axi_aw_ready            = w_aw_ready;
  assign bus.axi_w_ready             = w_w_ready;
  assign bus.axi_b_valid             = (r_state == S_RESP);
  assign bus.axi_b_payload_resp      = ((r_state == S_RESP) & (r_err | r_lastmis)) ? 2'd2 : 2'd0;
  assign bus.axi_b_payload_id        = r_id;
  assign bus.native_cmd_valid        = w_cmd_act;
  assign bus.native_cmd_payload_we   = 1'b1;
  assign bus.native_cmd_payload_addr = NADDR_W'(r_addr >> SHIFT);
  assign bus.wdata_valid             = bus.axi_w_valid & w_data_act & ~r_err;
  assign bus.wdata_payload_data      = bus.axi_w_payload_data;
  assign bus.wdata_payload_we        = bus.axi_w_payload_strb;
endmodule

// File: tb/tb_axi_wr_native_bridge.sv
// Directed plus randomized bursts against an arithmetic address/response model of the write bridge.
module tb_axi_wr_native_bridge;
  localparam int DATA_W = 256, ADDR_W = 32, NADDR_W = 32, ID_W = 4, BYTES = DATA_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  axi_wr_native_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NADDR_W(NADDR_W), .ID_W(ID_W)) bus();

  axi_wr_native_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NADDR_W(NADDR_W), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rnd(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  // Native word address of beat i, straight from the AXI burst rules.
  function automatic logic [31:0] exp_native(input logic [31:0] a, input logic [1:0] b, input int len, input int i);
    longint aa, w, base;
    logic [31:0] byte_a;
    aa = longint'(a);
    case (b)
      2'd0: byte_a = a;
      2'd2: begin
        w      = longint'((len + 1) * BYTES);
        base   = aa - (aa % w);
        byte_a = 32'(base + ((aa - base) + longint'(i * BYTES)) % w);
      end
      default: byte_a = a + 32'(i * BYTES);
    endcase
    return byte_a >> 5;
  endfunction

  task automatic send_aw(input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len,
                         input logic [3:0] size, input logic [ID_W-1:0] id);
    bit ok;
    ok = 1'b0;
    bus.axi_aw_valid = 1'b1;
    bus.axi_aw_payload_addr = addr;
    bus.axi_aw_payload_burst = burst;
    bus.axi_aw_payload_len = len;
    bus.axi_aw_payload_size = size;
    bus.axi_aw_payload_id = id;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.axi_aw_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("aw_ready", 256'(ok), 256'(1));
    @(posedge clk); #1;
    bus.axi_aw_valid = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [1:0] burst, input int len,
                           input logic [3:0] size, input logic [ID_W-1:0] id, input int last_at,
                           input int cmd_pct, input int dat_pct, input int bhold);
    bit err, b_seen;
    int ncmd, nwd, nw, last_hs, b_iter, exp_beats;
    logic [255:0] wd;
    logic [1:0] exp_resp;
    err = (size != 4'd5) || (burst == 2'd3) ||
          (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    exp_resp  = (err || last_at != len) ? 2'd2 : 2'd0;
    exp_beats = err ? 0 : len + 1;
    ncmd = 0; nwd = 0; nw = 0; last_hs = -1; b_iter = -1; b_seen = 1'b0;
    bus.axi_b_ready = 1'b0;
    send_aw(addr, burst, 8'(len), size, id);
    for (int c = 0; c < 3000 && !b_seen; c++) begin
      bus.native_cmd_ready = (cmd_pct < 0) ? (c[0] == 1'b0) : rnd(cmd_pct);
      bus.wdata_ready = rnd(dat_pct);
      bus.axi_w_valid = rnd(dat_pct);
      for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom();
      bus.axi_w_payload_data = wd;
      bus.axi_w_payload_strb = $urandom();
      bus.axi_w_last = (nw == last_at);
      @(negedge clk);
      if (bus.axi_b_valid) begin
        b_seen = 1'b1;
        b_iter = c;
      end else begin
        if (c == 0 && !err) chk("first_cmd_valid", 256'(bus.native_cmd_valid), 256'(1));
        if (bus.native_cmd_valid && bus.native_cmd_ready) begin
          if (ncmd <= len) chk("cmd_addr", 256'(bus.native_cmd_payload_addr), 256'(exp_native(addr, burst, len, ncmd)));
          ncmd++;
          last_hs = c;
        end
        if (bus.wdata_valid && bus.wdata_ready) begin
          chk("wdata_data", bus.wdata_payload_data, wd);
          chk("wdata_we", 256'(bus.wdata_payload_we), 256'(bus.axi_w_payload_strb));
          nwd++;
        end
        if (bus.axi_w_valid && bus.axi_w_ready) begin
          nw++;
          last_hs = c;
        end
        @(posedge clk); #1;
      end
    end
    bus.native_cmd_ready = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.axi_w_valid = 1'b0;
    bus.axi_w_last = 1'b0;
    chk("b_seen", 256'(b_seen), 256'(1));
    if (b_seen) begin
      chk("b_latency", 256'(b_iter), 256'(last_hs + 1));
      chk("n_cmd", 256'(ncmd), 256'(exp_beats));
      chk("n_wdata", 256'(nwd), 256'(exp_beats));
      chk("n_w_accepted", 256'(nw), 256'(len + 1));
      chk("b_resp", 256'(bus.axi_b_payload_resp), 256'(exp_resp));
      chk("b_id", 256'(bus.axi_b_payload_id), 256'(id));
      for (int h = 0; h < bhold; h++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_b_valid", 256'(bus.axi_b_valid), 256'(1));
        chk("hold_b_resp", 256'(bus.axi_b_payload_resp), 256'(exp_resp));
        chk("hold_b_id", 256'(bus.axi_b_payload_id), 256'(id));
        chk("hold_aw_ready", 256'(bus.axi_aw_ready), 256'(0));
      end
      @(posedge clk); #1;
      bus.axi_b_ready = 1'b1;
      @(posedge clk); #1;
      bus.axi_b_ready = 1'b0;
      @(negedge clk);
      chk("b_released", 256'(bus.axi_b_valid), 256'(0));
      chk("aw_ready_after_b", 256'(bus.axi_aw_ready), 256'(1));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [1:0] bt;
    int ln, la, nw;
    bus.axi_aw_valid = 1'b0; bus.axi_aw_payload_addr = '0; bus.axi_aw_payload_burst = '0;
    bus.axi_aw_payload_len = '0; bus.axi_aw_payload_size = '0; bus.axi_aw_payload_id = '0;
    bus.axi_w_valid = 1'b0; bus.axi_w_last = 1'b0; bus.axi_w_payload_data = '0;
    bus.axi_w_payload_strb = '0; bus.axi_b_ready = 1'b0; bus.native_cmd_ready = 1'b0;
    bus.wdata_ready = 1'b0;

    @(negedge clk); @(negedge clk);
    chk("rst_aw_ready", 256'(bus.axi_aw_ready), 256'(0));
    chk("rst_w_ready", 256'(bus.axi_w_ready), 256'(0));
    chk("rst_b_valid", 256'(bus.axi_b_valid), 256'(0));
    chk("rst_cmd_valid", 256'(bus.native_cmd_valid), 256'(0));
    chk("rst_wdata_valid", 256'(bus.wdata_valid), 256'(0));
    chk("rst_b_resp", 256'(bus.axi_b_payload_resp), 256'(0));
    chk("rst_b_id", 256'(bus.axi_b_payload_id), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_aw_ready", 256'(bus.axi_aw_ready), 256'(1));
    @(posedge clk); #1;

    run_burst(32'h1000, 2'd1, 3, 4'd5, 4'h5, 3, 100, 100, 0);
    run_burst(32'h1060, 2'd2, 3, 4'd5, 4'h6, 3, 100, 100, 0);
    run_burst(32'h1060, 2'd0, 2, 4'd5, 4'h7, 2, 100, 100, 0);
    run_burst(32'h1000, 2'd1, 1, 4'd2, 4'h8, 1, 100, 100, 0);
    run_burst(32'h1000, 2'd1, 3, 4'd5, 4'h9, 1, -1, 100, 0);
    run_burst(32'h2000, 2'd1, 1, 4'd5, 4'hA, 1, 100, 100, 5);
    run_burst(32'h3000, 2'd1, 0, 4'd5, 4'hB, 0, 100, 100, 0);
    run_burst(32'h3000, 2'd2, 2, 4'd5, 4'hC, 2, 100, 100, 0);
    run_burst(32'h3000, 2'd3, 1, 4'd5, 4'hD, 1, 100, 100, 0);
    run_burst(32'hFFFF_FFC0, 2'd1, 3, 4'd5, 4'hE, 3, 100, 100, 0);
    run_burst(32'h0004_0000, 2'd1, 255, 4'd5, 4'hF, 255, 100, 100, 0);
    run_burst(32'h0000_5E20, 2'd2, 15, 4'd5, 4'h3, 15, 60, 70, 1);

    for (int t = 0; t < 25; t++) begin
      bt = 2'($urandom_range(2, 0));
      ln = (bt == 2'd2) ? (1 << $urandom_range(4, 1)) - 1 : int'($urandom_range(15, 0));
      la = ($urandom_range(9, 0) == 0) ? int'($urandom_range(16, 0)) : ln;
      run_burst($urandom(), bt, ln, 4'd5, ID_W'($urandom()), la,
                int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), int'($urandom_range(3, 0)));
    end

    // Reset in the middle of an INCR len=7 burst after two beats have gone through.
    send_aw(32'h2000, 2'd1, 8'd7, 4'd5, 4'h9);
    bus.native_cmd_ready = 1'b1; bus.wdata_ready = 1'b1; bus.axi_w_valid = 1'b1; bus.axi_w_last = 1'b0;
    nw = 0;
    for (int c = 0; c < 20 && nw < 2; c++) begin
      @(negedge clk);
      if (bus.axi_w_valid && bus.axi_w_ready) nw++;
      @(posedge clk); #1;
    end
    chk("pre_rst_beats", 256'(nw), 256'(2));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cmd_valid", 256'(bus.native_cmd_valid), 256'(0));
    chk("mid_rst_wdata_valid", 256'(bus.wdata_valid), 256'(0));
    chk("mid_rst_w_ready", 256'(bus.axi_w_ready), 256'(0));
    chk("mid_rst_b_valid", 256'(bus.axi_b_valid), 256'(0));
    chk("mid_rst_aw_ready", 256'(bus.axi_aw_ready), 256'(0));
    bus.native_cmd_ready = 1'b0; bus.wdata_ready = 1'b0; bus.axi_w_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_b_valid", 256'(bus.axi_b_valid), 256'(0));
    chk("post_rst_aw_ready", 256'(bus.axi_aw_ready), 256'(1));
    @(posedge clk); #1;
    run_burst(32'h4000, 2'd1, 2, 4'd5, 4'h2, 2, 100, 100, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
